// File: rtl/etpu_wb_host_seq_pkg.sv
// Shared eTPU host-sequencer definitions: slave address, per-job word counts, FSM encoding.
// Slave and initiator import these so both sides agree on counts and address.
package etpu_wb_host_seq_pkg;

   localparam logic [31:0] ETPU_BASE_ADDRESS    = 32'h3000_0000;
   localparam int          ETPU_N_WEIGHT        = 3;
   localparam int          ETPU_N_INPUT         = 6;
   localparam int          ETPU_N_RESULT        = 10;
   localparam int          ETPU_TIMEOUT_CYCLES  = 255;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WRITE = 3'd2,
      ST_GAP   = 3'd3,
      ST_READ  = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } state_t;

endpackage

// File: rtl/etpu_wb_host_seq.sv
// Wishbone initiator driving the eTPU slave port: weight writes, activation writes, result reads.
// Optional ack timeout with sticky err_o when ETPU_WBM_TIMEOUT_EN is defined.
module etpu_wb_host_seq
   import etpu_wb_host_seq_pkg::*;
#(
   parameter logic [31:0] BASE_ADDRESS   = ETPU_BASE_ADDRESS,
   parameter int          N_WEIGHT       = ETPU_N_WEIGHT,
   parameter int          N_INPUT        = ETPU_N_INPUT,
   parameter int          N_RESULT       = ETPU_N_RESULT
`ifdef ETPU_WBM_TIMEOUT_EN
   ,
   parameter int          TIMEOUT_CYCLES = ETPU_TIMEOUT_CYCLES
`endif
) (
   input  logic        caravel_wb_clk_i,
   input  logic        caravel_wb_rst_i,
   input  logic        start_i,
   input  logic [31:0] wr_data_i,
   input  logic        wr_valid_i,
   output logic        wr_ready_o,
   output logic [31:0] rd_data_o,
   output logic        rd_valid_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i
);

   localparam int N_WR = N_WEIGHT + N_INPUT;
   localparam int WW   = $clog2(N_WR + 1);
   localparam int RW   = $clog2(N_RESULT + 1);
   localparam logic [WW-1:0] WR_LAST = WW'(N_WR);
   localparam logic [RW-1:0] RD_LAST = RW'(N_RESULT);

   state_t          state;
   logic [WW-1:0]   wr_cnt;
   logic [RW-1:0]   rd_cnt;
   logic            tmo_hit;

   assign wr_ready_o = (state == ST_FETCH);

`ifdef ETPU_WBM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;

   // tmo_cnt holds (stb cycles so far - 1); the hit fires on the last allowed stb cycle
   assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge caravel_wb_clk_i or posedge caravel_wb_rst_i) begin
      if (caravel_wb_rst_i) begin
         tmo_cnt <= '0;
         err_o   <= 1'b0;
      end else begin
         tmo_cnt <= wbm_stb_o ? tmo_cnt + 1'b1 : '0;
         if (wbm_stb_o && !wbm_ack_i && tmo_hit)
            err_o <= 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign err_o   = 1'b0;
`endif

   always_ff @(posedge caravel_wb_clk_i or posedge caravel_wb_rst_i) begin
      if (caravel_wb_rst_i) begin
         state      <= ST_IDLE;
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         rd_data_o  <= '0;
         rd_valid_o <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         wbm_cyc_o  <= 1'b0;
         wbm_stb_o  <= 1'b0;
         wbm_we_o   <= 1'b0;
         wbm_sel_o  <= '0;
         wbm_adr_o  <= '0;
         wbm_dat_o  <= '0;
      end else begin
         done_o     <= 1'b0;
         rd_valid_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  wr_cnt <= '0;
                  rd_cnt <= '0;
                  busy_o <= 1'b1;
                  state  <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (wr_valid_i) begin
                  wbm_dat_o <= wr_data_i;
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  wbm_we_o  <= 1'b1;
                  wbm_sel_o <= 4'hF;
                  wbm_adr_o <= BASE_ADDRESS;
                  state     <= ST_WRITE;
               end
            end
            ST_WRITE, ST_READ: begin
               if (wbm_ack_i) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  wbm_we_o  <= 1'b0;
                  wbm_sel_o <= '0;
                  if (state == ST_WRITE) begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end else begin
                     rd_data_o  <= wbm_dat_i;
                     rd_valid_o <= 1'b1;
                     rd_cnt     <= rd_cnt + 1'b1;
                  end
                  state <= ST_GAP;
               end else if (tmo_hit) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  wbm_we_o  <= 1'b0;
                  wbm_sel_o <= '0;
                  busy_o    <= 1'b0;
                  state     <= ST_ERR;
               end
            end
            // The slave's registered ack echoes here once; it is deliberately not looked at.
            ST_GAP: begin
               if (wr_cnt < WR_LAST) begin
                  state <= ST_FETCH;
               end else if (rd_cnt < RD_LAST) begin
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  wbm_we_o  <= 1'b0;
                  wbm_sel_o <= 4'hF;
                  wbm_adr_o <= BASE_ADDRESS;
                  state     <= ST_READ;
               end else begin
                  done_o <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            ST_ERR:  state <= ST_ERR;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_etpu_wb_host_seq.sv
// Directed bench for etpu_wb_host_seq with a registered-ack Wishbone slave model.
module tb_etpu_wb_host_seq;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] wr_data_i = '0;
   logic        wr_valid_i = 1'b0;
   logic        wr_ready_o;
   logic [31:0] rd_data_o;
   logic        rd_valid_o, busy_o, done_o, err_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic        wbm_ack_i;
   logic [31:0] wbm_dat_i;

   int checks = 0;
   int errors = 0;

   // slave model state and logs
   logic        nack = 1'b0;
   int          wr_n = 0, rd_k = 0, rv_n = 0, done_n = 0, gap_viol = 0;
   int          rd_base = 0;
   logic        prev_end = 1'b0;
   logic [31:0] wr_dat [0:127];
   logic [31:0] wr_adr [0:127];
   logic [31:0] rv_dat [0:127];

   etpu_wb_host_seq dut (
      .caravel_wb_clk_i (clk),
      .caravel_wb_rst_i (rst),
      .start_i          (start_i),
      .wr_data_i        (wr_data_i),
      .wr_valid_i       (wr_valid_i),
      .wr_ready_o       (wr_ready_o),
      .rd_data_o        (rd_data_o),
      .rd_valid_o       (rd_valid_o),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .err_o            (err_o),
      .wbm_cyc_o        (wbm_cyc_o),
      .wbm_stb_o        (wbm_stb_o),
      .wbm_we_o         (wbm_we_o),
      .wbm_sel_o        (wbm_sel_o),
      .wbm_adr_o        (wbm_adr_o),
      .wbm_dat_o        (wbm_dat_o),
      .wbm_ack_i        (wbm_ack_i),
      .wbm_dat_i        (wbm_dat_i)
   );

   always #5 clk = ~clk;

   assign wbm_dat_i = 32'hA0 + 32'(rd_k - rd_base);

   // registered ack: follows stb one cycle later, so it echoes once into the gap cycle
   always @(posedge clk or posedge rst) begin
      if (rst) wbm_ack_i <= 1'b0;
      else     wbm_ack_i <= wbm_cyc_o && wbm_stb_o && !nack;
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
            if (wbm_we_o) begin
               if (wr_n < 128) begin
                  wr_dat[wr_n] <= wbm_dat_o;
                  wr_adr[wr_n] <= wbm_adr_o;
               end
               wr_n <= wr_n + 1;
            end else begin
               rd_k <= rd_k + 1;
            end
         end
         if (prev_end && wbm_stb_o) gap_viol <= gap_viol + 1;
         prev_end <= wbm_cyc_o && wbm_stb_o && wbm_ack_i;
         if (rd_valid_o) begin
            if (rv_n < 128) rv_dat[rv_n] <= rd_data_o;
            rv_n <= rv_n + 1;
         end
         if (done_o) done_n <= done_n + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Full job with optional hold of wr_valid_i before word index hold_idx; checks results.
   task automatic run_job(input string tag, input int hold_idx, input int hold_len);
      int widx, held, cyc_bad, n, d0, wb, vb, gb;
      widx = 0; held = 0; cyc_bad = 0; n = 0;
      d0 = done_n; wb = wr_n; vb = rv_n; gb = gap_viol;
      rd_base = rd_k;
      @(negedge clk); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      while (done_n == d0 && n < 3000) begin
         if (widx == hold_idx && held < hold_len) begin
            wr_valid_i = 1'b0;
            if (wr_ready_o) begin
               held++;
               if (wbm_cyc_o) cyc_bad++;
            end
         end else begin
            wr_valid_i = (widx < 9);
            wr_data_i  = 32'h11 + 32'(widx);
            if (wr_valid_i && wr_ready_o) widx++;
         end
         start_i = (n == 15);
         n++;
         @(negedge clk);
      end
      start_i = 1'b0; wr_valid_i = 1'b0;
      chk({tag, " job_finished"}, 32'(n < 3000), 32'd1);
      repeat (10) @(negedge clk);
      chk({tag, " writes"}, 32'(wr_n - wb), 32'd9);
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("%s wdat%0d", tag, k), wr_dat[wb+k], 32'h11 + 32'(k));
         chk($sformatf("%s wadr%0d", tag, k), wr_adr[wb+k], BASE);
      end
      chk({tag, " reads"}, 32'(rd_k - rd_base), 32'd10);
      chk({tag, " rd_valid_cnt"}, 32'(rv_n - vb), 32'd10);
      for (int k = 0; k < 10; k++)
         chk($sformatf("%s rdat%0d", tag, k), rv_dat[vb+k], 32'hA0 + 32'(k));
      chk({tag, " done_cnt"}, 32'(done_n - d0), 32'd1);
      chk({tag, " gap_stb"}, 32'(gap_viol - gb), 32'd0);
      chk({tag, " busy_after"}, {31'd0, busy_o}, 32'd0);
      chk({tag, " cyc_after"}, {31'd0, wbm_cyc_o}, 32'd0);
      if (hold_len > 0) begin
         chk({tag, " held"}, 32'(held), 32'(hold_len));
         chk({tag, " cyc_in_hold"}, 32'(cyc_bad), 32'd0);
      end
   endtask

   initial begin
      int n, wb;
      repeat (2) @(negedge clk);
      chk("rst cyc", {31'd0, wbm_cyc_o}, 32'd0);
      chk("rst stb", {31'd0, wbm_stb_o}, 32'd0);
      chk("rst we",  {31'd0, wbm_we_o}, 32'd0);
      chk("rst sel", {28'd0, wbm_sel_o}, 32'd0);
      chk("rst adr", wbm_adr_o, 32'd0);
      chk("rst dat", wbm_dat_o, 32'd0);
      chk("rst busy", {31'd0, busy_o}, 32'd0);
      chk("rst done", {31'd0, done_o}, 32'd0);
      chk("rst err", {31'd0, err_o}, 32'd0);
      chk("rst rdv", {31'd0, rd_valid_o}, 32'd0);
      chk("rst rdd", rd_data_o, 32'd0);
      chk("rst rdy", {31'd0, wr_ready_o}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_job("job1", 99, 0);
      run_job("hold", 3, 20);

      // reset during the 5th write's strobe, then a full rerun
      wb = wr_n; n = 0;
      @(negedge clk); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      while (!((wr_n - wb) == 4 && wbm_stb_o) && n < 500) begin
         wr_valid_i = 1'b1;
         wr_data_i  = 32'h11 + 32'(wr_n - wb);
         n++;
         @(negedge clk);
      end
      chk("mid reached_5th", 32'(n < 500), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid cyc", {31'd0, wbm_cyc_o}, 32'd0);
      chk("mid stb", {31'd0, wbm_stb_o}, 32'd0);
      chk("mid busy", {31'd0, busy_o}, 32'd0);
      wr_valid_i = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      run_job("rerun", 99, 0);

`ifdef ETPU_WBM_TIMEOUT_EN
      nack = 1'b1; n = 0;
      @(negedge clk); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      wr_valid_i = 1'b1; wr_data_i = 32'h55;
      while (!wbm_stb_o && n < 50) begin n++; @(negedge clk); end
      wr_valid_i = 1'b0;
      n = 0;
      while (wbm_stb_o && n < 400) begin n++; @(negedge clk); end
      chk("tmo stb_cycles", 32'(n), 32'd255);
      chk("tmo err", {31'd0, err_o}, 32'd1);
      chk("tmo busy", {31'd0, busy_o}, 32'd0);
      start_i = 1'b1; wr_valid_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      repeat (5) @(negedge clk);
      chk("tmo start_ignored", {31'd0, wbm_cyc_o}, 32'd0);
      chk("tmo busy2", {31'd0, busy_o}, 32'd0);
      chk("tmo err_sticky", {31'd0, err_o}, 32'd1);
      wr_valid_i = 1'b0; nack = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("tmo err_cleared", {31'd0, err_o}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
